// File: rtl/adder_rr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_sched_if
//  Description : Request/response bundle for the shared-adder scheduler.
//                Requesters pack their operands side by side: requester i
//                uses bits [i*W +: W] of req_a and req_b.
//                master : requesters and result consumer (drive requests,
//                         accept results)
//                slave  : the scheduler
//  Signals     : req_valid/req_ready/req_cin/req_chain [NREQ]
//                req_a/req_b [NREQ*W]
//                rsp_valid, rsp_ready, rsp_id[3], rsp_sum[W], rsp_cout, busy
//  Revision    : 1.0  initial release
// ============================================================================
interface adder_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 14
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/adder_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_sched
//  Description : Shares one W-bit parallel-prefix adder among NREQ
//                requesters. Round-robin arbitration, two pipeline stages
//                (operand register -> adder -> result register), one op per
//                cycle. Chained beats lock the grant to one requester and
//                take their carry-in from the previous beat's carry-out.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active high
//                bus  - adder_rr_sched_if.slave (requests, result, busy)
//  Parameters  : NREQ - number of requesters, 2..8
//                W    - operand width, tied to the adder width (14)
//  Revision    : 1.0  initial release
// ============================================================================
module adder_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 14
) (
    input  logic            clk,
    input  logic            rst,
    adder_rr_sched_if.slave bus
);
    localparam int c_PW   = $clog2(NREQ);
    localparam int c_LVLS = $clog2(W);

    // Arbitration / lock state
    logic [c_PW-1:0] ptr_q;
    logic            lock_q;
    logic [c_PW-1:0] lock_id_q;
    logic            chain_carry_q;

    // Stage 1: operands
    logic            s1_valid_q;
    logic [W-1:0]    s1_a_q;
    logic [W-1:0]    s1_b_q;
    logic            s1_cin_q;
    logic [c_PW-1:0] s1_id_q;

    // Stage 2: result
    logic            s2_valid_q;
    logic [W-1:0]    s2_sum_q;
    logic            s2_cout_q;
    logic [c_PW-1:0] s2_id_q;

    logic [NREQ-1:0] w_grant;
    logic [c_PW-1:0] w_gnt_id;
    logic            w_gnt_vld;
    logic            w_s2_free;
    logic            w_s1_free;
    logic            w_xfer;
    logic            w_acc;
    logic            w_cin_sel;
    logic [c_PW-1:0] w_ptr_nxt;
    logic [W-1:0]    w_sum;
    logic            w_cout;

    assign w_s2_free = !s2_valid_q | bus.rsp_ready;
    assign w_s1_free = !s1_valid_q | w_s2_free;
    assign w_xfer    = s1_valid_q & w_s2_free;

    // ------------------------------------------------------------------
    // Arbitration: locked -> only lock_id; otherwise first valid from ptr.
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        idx       = 0;
        w_grant   = '0;
        w_gnt_id  = '0;
        w_gnt_vld = 1'b0;
        if (lock_q) begin
            if (bus.req_valid[lock_id_q]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = lock_id_q;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!w_gnt_vld && bus.req_valid[c_PW'(idx)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = c_PW'(idx);
                end
            end
        end
        w_grant[w_gnt_id] = w_gnt_vld;
    end

    assign bus.req_ready = w_grant & {NREQ{w_s1_free & ~rst}};
    assign w_acc         = w_gnt_vld & w_s1_free & ~rst;
    assign w_ptr_nxt     = (w_gnt_id == c_PW'(NREQ - 1)) ? '0 : w_gnt_id + c_PW'(1);

    // A chained beat accepted while its predecessor still sits in S1 can
    // only happen when S1 is moving to S2 this same cycle, so the
    // predecessor's carry is the live adder output rather than the
    // not-yet-updated chain_carry register.
    always_comb begin
        if (lock_q) begin
            w_cin_sel = s1_valid_q ? w_cout : chain_carry_q;
        end else begin
            w_cin_sel = bus.req_cin[w_gnt_id];
        end
    end

    // ------------------------------------------------------------------
    // Parallel-prefix adder (Ladner-Fischer/Sklansky tree) on S1.
    // Carry-in is folded into bit 0's generate, so gg[LVLS][i] is the
    // carry out of bit i.
    // ------------------------------------------------------------------
    logic w_gg [0:c_LVLS][0:W-1];
    logic w_pp [0:c_LVLS-1][0:W-1];

    for (genvar i = 0; i < W; i++) begin : g_init
        assign w_pp[0][i] = s1_a_q[i] ^ s1_b_q[i];
        if (i == 0) begin : g_lsb
            assign w_gg[0][i] = (s1_a_q[i] & s1_b_q[i]) | (w_pp[0][i] & s1_cin_q);
        end else begin : g_other
            assign w_gg[0][i] = s1_a_q[i] & s1_b_q[i];
        end
    end

    for (genvar l = 0; l < c_LVLS; l++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (((i >> l) & 1) == 1) begin : g_merge
                localparam int c_J = ((i >> l) << l) - 1;
                assign w_gg[l+1][i] = w_gg[l][i] | (w_pp[l][i] & w_gg[l][c_J]);
                if (l < c_LVLS - 1) begin : g_prop
                    assign w_pp[l+1][i] = w_pp[l][i] & w_pp[l][c_J];
                end
            end else begin : g_pass
                assign w_gg[l+1][i] = w_gg[l][i];
                if (l < c_LVLS - 1) begin : g_prop
                    assign w_pp[l+1][i] = w_pp[l][i];
                end
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_sum
        if (i == 0) begin : g_lsb
            assign w_sum[i] = w_pp[0][i] ^ s1_cin_q;
        end else begin : g_other
            assign w_sum[i] = w_pp[0][i] ^ w_gg[c_LVLS][i-1];
        end
    end
    assign w_cout = w_gg[c_LVLS][W-1];

    // ------------------------------------------------------------------
    // Pipeline and arbitration state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            lock_q        <= 1'b0;
            lock_id_q     <= '0;
            chain_carry_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_cin_q      <= 1'b0;
            s1_id_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_sum_q      <= '0;
            s2_cout_q     <= 1'b0;
            s2_id_q       <= '0;
        end else begin
            if (w_acc) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= bus.req_a[int'(w_gnt_id)*W +: W];
                s1_b_q     <= bus.req_b[int'(w_gnt_id)*W +: W];
                s1_cin_q   <= w_cin_sel;
                s1_id_q    <= w_gnt_id;
                if (bus.req_chain[w_gnt_id]) begin
                    lock_q    <= 1'b1;
                    lock_id_q <= w_gnt_id;
                end else begin
                    lock_q <= 1'b0;
                    ptr_q  <= w_ptr_nxt;
                end
            end else if (w_xfer) begin
                s1_valid_q <= 1'b0;
            end

            if (w_xfer) begin
                s2_valid_q    <= 1'b1;
                s2_sum_q      <= w_sum;
                s2_cout_q     <= w_cout;
                s2_id_q       <= s1_id_q;
                chain_carry_q <= w_cout;
            end else if (bus.rsp_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_id    = 3'(s2_id_q);
    assign bus.rsp_sum   = s2_sum_q;
    assign bus.rsp_cout  = s2_cout_q;
    assign bus.busy      = s1_valid_q | s2_valid_q | lock_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_rr_sched
//  Description : Directed bench for adder_rr_sched. Per-requester operation
//                queues feed the request side; every accepted operation
//                pushes its hand-computed result onto a scoreboard queue that
//                a separate monitor drains as results are handed off.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 14;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic        cin;
        logic        chain;
        logic [13:0] es;
        logic        ec;
        int          dly;
    } op_t;

    typedef struct {
        int          id;
        logic [13:0] sum;
        logic        cout;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic chk_lat;
    int   cyc = 0;
    int   nchecks = 0;
    int   nfail = 0;
    int   nrsp = 0;

    op_t  sq [NREQ][$];
    int   wt [NREQ];
    exp_t exp_q[$];
    int   acc_log[$];
    int   ord_exp[$];

    adder_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    adder_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic push_op(input int r, input logic [13:0] a, input logic [13:0] b,
                           input logic cin, input logic chain,
                           input logic [13:0] es, input logic ec, input int dly);
        op_t o;
        o.a = a; o.b = b; o.cin = cin; o.chain = chain;
        o.es = es; o.ec = ec; o.dly = dly;
        if (sq[r].size() == 0) wt[r] = dly;
        sq[r].push_back(o);
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (sq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Request driver: present queue heads shortly after each rising edge.
    initial begin
        logic [NREQ-1:0]   v;
        logic [NREQ-1:0]   c;
        logic [NREQ-1:0]   ch;
        logic [NREQ*W-1:0] av;
        logic [NREQ*W-1:0] bv;
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_cin = '0; bus.req_chain = '0;
        forever begin
            @(posedge clk);
            #2;
            v = '0; c = '0; ch = '0; av = '0; bv = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (sq[i].size() > 0) begin
                    if (wt[i] > 0) begin
                        wt[i]--;
                    end else begin
                        v[i]          = 1'b1;
                        av[i*W +: W]  = sq[i][0].a;
                        bv[i*W +: W]  = sq[i][0].b;
                        c[i]          = sq[i][0].cin;
                        ch[i]         = sq[i][0].chain;
                    end
                end
            end
            bus.req_valid = v; bus.req_a = av; bus.req_b = bv;
            bus.req_cin = c; bus.req_chain = ch;
        end
    end

    // Accept bookkeeping: log grant order and push the expected result.
    initial forever begin
        op_t  o;
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] && sq[i].size() > 0) begin
                    o = sq[i].pop_front();
                    acc_log.push_back(i);
                    e.id = i; e.sum = o.es; e.cout = o.ec; e.acc_cyc = cyc;
                    exp_q.push_back(e);
                    if (sq[i].size() > 0) wt[i] = sq[i][0].dly;
                end
            end
        end
    end

    // Result monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("rsp%0d_id_cout_sum", nrsp),
                    32'({bus.rsp_id, bus.rsp_cout, bus.rsp_sum}),
                    32'({3'(e.id), e.cout, e.sum}));
                if (chk_lat) chk($sformatf("rsp%0d_latency", nrsp), 32'(cyc - e.acc_cyc), 32'd2);
            end
            nrsp++;
        end
    end

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (n < 300 && !(all_empty() && exp_q.size() == 0 && !bus.rsp_valid)) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(n >= 300), 32'd0);
        chk({nm, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_order(input string nm);
        chk({nm, "_accept_count"}, 32'(acc_log.size()), 32'(ord_exp.size()));
        for (int k = 0; k < ord_exp.size() && k < acc_log.size(); k++)
            chk($sformatf("%s_accept%0d", nm, k), 32'(acc_log[k]), 32'(ord_exp[k]));
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            sq[i].delete();
            wt[i] = 0;
        end
        exp_q.delete();
        acc_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        chk_lat = 1'b0;
        bus.rsp_ready = 1'b1;

        // Reset state, with a request already presented
        push_op(0, 14'h3FFF, 14'h0001, 1'b0, 1'b0, 14'h0000, 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        chk("rst_rsp_cout",  32'(bus.rsp_cout),  32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // 1: single op with full carry ripple
        @(posedge clk); #1;
        rst = 1'b0;
        chk_lat = 1'b1;
        drain("t1");
        ord_exp = {0};
        check_order("t1");

        // 2: all requesters valid from ptr=0
        @(posedge clk); #1; rst = 1'b1; flush();
        @(posedge clk); #1; rst = 1'b0;
        push_op(0, 14'h0001, 14'h0002, 1'b0, 1'b0, 14'h0003, 1'b0, 0);
        push_op(0, 14'h0ABC, 14'h0544, 1'b0, 1'b0, 14'h1000, 1'b0, 0);
        push_op(1, 14'h1234, 14'h0111, 1'b1, 1'b0, 14'h1346, 1'b0, 0);
        push_op(2, 14'h2000, 14'h2000, 1'b0, 1'b0, 14'h0000, 1'b1, 0);
        push_op(3, 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 14'h3FFF, 1'b1, 0);
        drain("t2");
        ord_exp = {0, 1, 2, 3, 0};
        check_order("t2");

        // 3: backpressure for 5 cycles (ptr=1)
        @(posedge clk); #1;
        chk_lat = 1'b0;
        bus.rsp_ready = 1'b0;
        acc_log.delete();
        push_op(1, 14'h0100, 14'h0200, 1'b0, 1'b0, 14'h0300, 1'b0, 0);
        push_op(1, 14'h3000, 14'h1000, 1'b0, 1'b0, 14'h0000, 1'b1, 0);
        push_op(1, 14'h0FFF, 14'h0001, 1'b0, 1'b0, 14'h1000, 1'b0, 0);
        push_op(1, 14'h0003, 14'h0004, 1'b1, 1'b0, 14'h0008, 1'b0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t3_stall_req_ready", 32'(bus.req_ready), 32'd0);
        chk("t3_stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t3_stall_held_rsp",  32'({bus.rsp_id, bus.rsp_cout, bus.rsp_sum}),
            32'({3'd1, 1'b0, 14'h0300}));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        drain("t3");
        ord_exp = {1, 1, 1, 1};
        check_order("t3");

        // 4: three-beat chain on req2, req1 competing (ptr=2)
        @(posedge clk); #1;
        chk_lat = 1'b1;
        acc_log.delete();
        push_op(2, 14'h3FFF, 14'h0001, 1'b0, 1'b1, 14'h0000, 1'b1, 0);
        push_op(2, 14'h0000, 14'h0000, 1'b0, 1'b1, 14'h0001, 1'b0, 0);
        push_op(2, 14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 14'h3FFE, 1'b1, 0);
        push_op(1, 14'h0005, 14'h0005, 1'b0, 1'b0, 14'h000A, 1'b0, 0);
        drain("t4");
        ord_exp = {2, 2, 2, 1};
        check_order("t4");

        // 5: chain on req1 with a 3-cycle gap; req0/req3 wait (ptr=2)
        @(posedge clk); #1;
        acc_log.delete();
        push_op(1, 14'h3FFF, 14'h0002, 1'b0, 1'b1, 14'h0001, 1'b1, 0);
        push_op(1, 14'h0010, 14'h0020, 1'b0, 1'b0, 14'h0031, 1'b0, 3);
        push_op(0, 14'h0001, 14'h0001, 1'b0, 1'b0, 14'h0002, 1'b0, 1);
        push_op(3, 14'h0002, 14'h0002, 1'b0, 1'b0, 14'h0004, 1'b0, 1);
        drain("t5");
        ord_exp = {1, 1, 3, 0};
        check_order("t5");

        // 6: reset with both stages full and the grant locked
        @(posedge clk); #1;
        chk_lat = 1'b0;
        bus.rsp_ready = 1'b0;
        acc_log.delete();
        push_op(2, 14'h3FFF, 14'h0001, 1'b0, 1'b1, 14'h0000, 1'b1, 0);
        push_op(2, 14'h0000, 14'h0000, 1'b0, 1'b1, 14'h0001, 1'b0, 0);
        push_op(2, 14'h0001, 14'h0001, 1'b0, 1'b0, 14'h0003, 1'b0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t6_pre_busy",      32'(bus.busy),      32'd1);
        chk("t6_pre_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        flush();
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_rst_busy",      32'(bus.busy),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        chk_lat = 1'b1;
        push_op(0, 14'h0100, 14'h0001, 1'b0, 1'b0, 14'h0101, 1'b0, 0);
        push_op(3, 14'h0001, 14'h0001, 1'b1, 1'b0, 14'h0003, 1'b0, 0);
        drain("t6");
        ord_exp = {0, 3};
        check_order("t6");

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
`default_nettype wire
